// File: rtl/intersection_phase_scheduler.sv
// Purpose : two-road intersection phase sequencer (main/side road lamps plus a pedestrian walk phase).
// Latency : Moore outputs decoded from the state register; a request is acted on at the next qualifying tick.
// Backpres: none; requests are level/pulse inputs, and the pedestrian request is latched until it is served.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   side_sensor, ped_req    side-road vehicle presence (level), pedestrian button (pulse or level)
//   main_*/side_* lamps     one-hot red/yellow/green per road
//   walk, ped_pending       pedestrian walk lamp, latched pedestrian request
//   phase                   current state encoding (debug)
module intersection_phase_scheduler #(
    parameter int TICK_DIV       = 50000000,
    parameter int MAIN_MIN_GREEN = 20,
    parameter int SIDE_GREEN_T   = 10,
    parameter int YELLOW_T       = 3,
    parameter int ALL_RED_T      = 1,
    parameter int WALK_T         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_sensor,
    input  logic       ped_req,
    output logic       main_red,
    output logic       main_yellow,
    output logic       main_green,
    output logic       side_red,
    output logic       side_yellow,
    output logic       side_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_MAIN_GREEN  = 3'd0,
        S_MAIN_YELLOW = 3'd1,
        S_ALL_RED_A   = 3'd2,
        S_SIDE_GREEN  = 3'd3,
        S_SIDE_YELLOW = 3'd4,
        S_ALL_RED_B   = 3'd5,
        S_PED_WALK    = 3'd6
    } state_e;

    // Counter widths sized from the parameters; the timer only ever needs to reach duration-1.
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int M1   = (MAIN_MIN_GREEN > SIDE_GREEN_T) ? MAIN_MIN_GREEN : SIDE_GREEN_T;
    localparam int M2   = (YELLOW_T > ALL_RED_T) ? YELLOW_T : ALL_RED_T;
    localparam int M3   = (M1 > M2) ? M1 : M2;
    localparam int MAXD = (M3 > WALK_T) ? M3 : WALK_T;
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] MG_LAST  = TW'(MAIN_MIN_GREEN - 1);
    localparam logic [TW-1:0] SG_LAST  = TW'(SIDE_GREEN_T - 1);
    localparam logic [TW-1:0] Y_LAST   = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LAST  = TW'(ALL_RED_T - 1);
    localparam logic [TW-1:0] W_LAST   = TW'(WALK_T - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ped_pending_q, ped_pending_d;
    logic            tick;
    logic [TW-1:0]   dur_last;
    logic            timer_done;

    // Free-running prescaler; deliberately not realigned on state changes.
    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_comb begin
        dur_last = '0;
        case (state_q)
            S_MAIN_GREEN:                dur_last = MG_LAST;
            S_MAIN_YELLOW, S_SIDE_YELLOW: dur_last = Y_LAST;
            S_ALL_RED_A, S_ALL_RED_B:    dur_last = AR_LAST;
            S_SIDE_GREEN:                dur_last = SG_LAST;
            S_PED_WALK:                  dur_last = W_LAST;
            default:                     dur_last = '0;
        endcase
    end

    assign timer_done = tick && (timer_q == dur_last);

    // State register (with timer, prescaler and pedestrian latch).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_ALL_RED_B;
            pre_q         <= '0;
            timer_q       <= '0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_q         <= pre_d;
            timer_q       <= timer_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_MAIN_GREEN:  if (timer_done && (side_sensor || ped_pending_q)) state_d = S_MAIN_YELLOW;
            S_MAIN_YELLOW: if (timer_done) state_d = S_ALL_RED_A;
            S_ALL_RED_A:   if (timer_done) state_d = ped_pending_q ? S_PED_WALK : S_SIDE_GREEN;
            S_SIDE_GREEN:  if (timer_done) state_d = S_SIDE_YELLOW;
            S_SIDE_YELLOW: if (timer_done) state_d = S_ALL_RED_B;
            S_ALL_RED_B:   if (timer_done) state_d = S_MAIN_GREEN;
            S_PED_WALK:    if (timer_done) state_d = S_ALL_RED_B;
            default:       state_d = S_ALL_RED_B;
        endcase
    end

    // Timer restarts on every state entry; in main green it parks at its last value
    // so a late request is served on the very next tick.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (tick && !(state_q == S_MAIN_GREEN && timer_q == MG_LAST)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Button presses during a walk are dropped so a held button gives one walk per cycle.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (state_q == S_PED_WALK && state_d != state_q) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && state_q != S_PED_WALK) begin
            ped_pending_d = 1'b1;
        end
    end

    // Output decode (Moore, state register only).
    always_comb begin
        main_red    = 1'b0;
        main_yellow = 1'b0;
        main_green  = 1'b0;
        side_red    = 1'b0;
        side_yellow = 1'b0;
        side_green  = 1'b0;
        walk        = 1'b0;
        case (state_q)
            S_MAIN_GREEN:  begin main_green  = 1'b1; side_red    = 1'b1; end
            S_MAIN_YELLOW: begin main_yellow = 1'b1; side_red    = 1'b1; end
            S_SIDE_GREEN:  begin main_red    = 1'b1; side_green  = 1'b1; end
            S_SIDE_YELLOW: begin main_red    = 1'b1; side_yellow = 1'b1; end
            S_PED_WALK:    begin main_red    = 1'b1; side_red    = 1'b1; walk = 1'b1; end
            default:       begin main_red    = 1'b1; side_red    = 1'b1; end
        endcase
    end

    assign ped_pending = ped_pending_q;
    assign phase       = state_q;

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Sequences a two-road intersection: a main road, a side road and one pedestrian crossing. It produces one-hot red/yellow/green for each road plus a walk signal. Main road rests on green. Side-road vehicle sensor or pedestrian button requests drive the cycle through yellow and all-red clearance intervals. All timing is in ticks derived from an internal prescaler, so the block sits directly between the board clock and the lamp drivers.

Parameters:
TICK_DIV, 50000000, clocks per tick (1 s at 50 MHz); >=1, where 1 means a tick every cycle
MAIN_MIN_GREEN, 20, minimum main-green duration in ticks (>=1)
SIDE_GREEN_T, 10, side-green duration in ticks (>=1)
YELLOW_T, 3, yellow duration in ticks, both roads (>=1)
ALL_RED_T, 1, all-red clearance duration in ticks (>=1)
WALK_T, 8, pedestrian walk duration in ticks (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state on the next clk edge
side_sensor  input  1  side-road vehicle present, level
ped_req  input  1  pedestrian button, any-cycle pulse or level
main_red  output  1  main road red lamp
main_yellow  output  1  main road yellow lamp
main_green  output  1  main road green lamp
side_red  output  1  side road red lamp
side_yellow  output  1  side road yellow lamp
side_green  output  1  side road green lamp
walk  output  1  pedestrian walk lamp
ped_pending  output  1  latched pedestrian request
phase  output  3  current state encoding, for debug

Behaviour:
- Reset is synchronous and active-high, on clk.
- Reset: state=ALL_RED_B, prescaler=0, state timer=0, ped_pending=0.
- Reset outputs: main_red=1, side_red=1, all other lamps=0, walk=0, phase=5.
- Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 for the single cycle when the count is TICK_DIV-1.
- State timer clears on every state entry and increments on tick.
- A timed state with duration D exits on the cycle where tick=1 and timer==D-1. The state therefore lasts exactly D*TICK_DIV clocks. The prescaler is not reset on state change.
- States and encoding: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_A=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_B=5, PED_WALK=6. Encoding 7 is unreachable; if entered, go to ALL_RED_B next cycle.
- MAIN_GREEN: the timer saturates at MAIN_MIN_GREEN-1. On a tick with timer at MAIN_MIN_GREEN-1, go to MAIN_YELLOW if (side_sensor | ped_pending) is 1 that cycle; otherwise hold indefinitely.
- MAIN_YELLOW lasts YELLOW_T, then goes to ALL_RED_A.
- ALL_RED_A lasts ALL_RED_T, then goes to PED_WALK if ped_pending=1, else to SIDE_GREEN. Pedestrian has priority.
- PED_WALK lasts WALK_T, then goes to ALL_RED_B.
- SIDE_GREEN lasts SIDE_GREEN_T, then goes to SIDE_YELLOW. The side_sensor value is ignored here; the duration is fixed.
- SIDE_YELLOW lasts YELLOW_T, then goes to ALL_RED_B.
- ALL_RED_B lasts ALL_RED_T, then goes to MAIN_GREEN.
- ped_pending is set on any cycle with ped_req=1 while state != PED_WALK.
- ped_pending clears on the PED_WALK exit transition. ped_req during PED_WALK is ignored.
- A held button therefore causes at most one walk per cycle of the intersection.
- Side demand arriving while a walk is in progress is served on the next cycle after MAIN_MIN_GREEN.
- Outputs are a Moore decode of the state register only, with no input-to-output paths:
  - MAIN_GREEN: main_green, side_red.
  - MAIN_YELLOW: main_yellow, side_red.
  - SIDE_GREEN: main_red, side_green.
  - SIDE_YELLOW: main_red, side_yellow.
  - ALL_RED_A, ALL_RED_B: main_red, side_red.
  - PED_WALK: main_red, side_red, walk.
- Invariants, checked by the bench every cycle:
  - Exactly one lamp per road is on.
  - main_green and side_green are never on together.
  - walk=1 implies both reds are on.
- Reset mid-operation: at the next edge, return to reset values regardless of state. The prescaler restarts at 0.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, MAIN_MIN_GREEN=6, SIDE_GREEN_T=4, YELLOW_T=2, ALL_RED_T=1, WALK_T=3; clk period 20 ns; reset high 3 cycles, then low.
1. Power-up, no requests -> both red for 4 clocks after reset falls, then MAIN_GREEN (phase=0). Main green holds for 1000 clocks with no transition.
2. side_sensor=1 held from reset release -> main green lasts 24 clocks, then yellow 8, all-red 4, side green 16, side yellow 8, all-red 4. The sequence then repeats.
3. One-cycle ped_req pulse during main green, side_sensor=0 -> ped_pending=1 at the next edge. Sequence is MAIN_YELLOW, ALL_RED_A, walk=1 for 12 clocks, ALL_RED_B, MAIN_GREEN. ped_pending drops when walk ends; side_green is never asserted.
4. ped_req and side_sensor both high -> PED_WALK is served first. After ALL_RED_B and 6 ticks of main green, the cycle proceeds to SIDE_GREEN. ped_req pulses during walk do not re-set ped_pending.
5. reset asserted for 1 cycle during SIDE_GREEN -> next edge gives phase=5, main_red=side_red=1, ped_pending=0. MAIN_GREEN follows exactly 4 clocks after reset falls.
6. Random side_sensor/ped_req for 100000 clocks -> no invariant violation. Every state dwell equals its parameter times 4 clocks, except MAIN_GREEN, which is at least 24 clocks.
